// File: rtl/song_select_controller.sv
// rtl/song_select_controller.sv - prev/pause/next song selector with debounce and auto-repeat

// Two-flop synchroniser followed by a counting debouncer for one raw button.
module song_select_debounce #(
  parameter int DEBOUNCE_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser chain, debounced level and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive disagreeing cycles; flip the level once the run is long enough.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

module song_select_controller #(
  parameter int         NUM_SONGS    = 4,
  parameter int         SONG_W       = 2,
  parameter int         DEBOUNCE_CYC = 2_000_000,
  parameter int         HOLD_CYC     = 100_000_000,
  parameter int         REPEAT_CYC   = 25_000_000,
  parameter logic [2:0] AUTO_MODE    = 3'b011,
  parameter logic [2:0] LEARN_MODE   = 3'b111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        button,
  input  logic [2:0]        mode,
  output logic [SONG_W-1:0] song_num,
  output logic              pause,
  output logic              song_changed
);

  localparam int RPT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } rpt_state_e;

  logic [2:0]        deb;
  logic [2:0]        deb_prev_q;
  logic [2:0]        rise;
  logic [1:0]        dir_deb;
  logic [1:0]        dir_rise;
  logic [1:0]        fire;
  logic              enable;
  logic              mode_chg;
  logic              both_held;
  logic [2:0]        mode_q;
  logic [SONG_W-1:0] song_q, song_d;
  logic              pause_q, pause_d;
  logic              changed_q, changed_d;
  rpt_state_e        state_q [2];
  rpt_state_e        state_d [2];
  logic [CNT_W-1:0]  cnt_q [2];
  logic [CNT_W-1:0]  cnt_d [2];

  for (genvar b = 0; b < 3; b++) begin : g_btn
    song_select_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (button[b]),
      .level_o(deb[b])
    );
  end

  assign rise      = deb & ~deb_prev_q;
  // Index 0 is prev (button 0), index 1 is next (button 2).
  assign dir_deb   = {deb[2], deb[0]};
  assign dir_rise  = {rise[2], rise[0]};
  assign enable    = (mode == AUTO_MODE) || (mode == LEARN_MODE);
  assign mode_chg  = (mode != mode_q);
  assign both_held = deb[0] & deb[2];

  // Edge-detect history, stored mode, song/pause state and the change strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_prev_q <= '0;
      mode_q     <= '0;
      song_q     <= '0;
      pause_q    <= 1'b0;
      changed_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      deb_prev_q <= deb;
      mode_q     <= mode;
      song_q     <= song_d;
      pause_q    <= pause_d;
      changed_q  <= changed_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Per-direction press / hold / repeat state machine producing step requests.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      fire[i]    = 1'b0;
      if (!enable || !dir_deb[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (dir_rise[i]) begin
              fire[i]    = 1'b1;
              state_d[i] = ST_HOLD;
              cnt_d[i]   = '0;
            end
          end
          ST_HOLD: begin
            if (both_held) begin
              cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(HOLD_CYC - 1)) begin
              fire[i]    = 1'b1;
              state_d[i] = ST_REPEAT;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (both_held) begin
              cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(REPEAT_CYC - 1)) begin
              fire[i] = 1'b1;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Song / pause update: mode change and disable win, then a single-direction step, then pause.
  always_comb begin
    song_d    = song_q;
    pause_d   = pause_q;
    changed_d = 1'b0;
    if (mode_chg || !enable) begin
      pause_d = 1'b0;
    end else if (fire[1] && !fire[0]) begin
      song_d    = (song_q == SONG_W'(NUM_SONGS - 1)) ? '0 : song_q + SONG_W'(1);
      pause_d   = 1'b0;
      changed_d = 1'b1;
    end else if (fire[0] && !fire[1]) begin
      song_d    = (song_q == '0) ? SONG_W'(NUM_SONGS - 1) : song_q - SONG_W'(1);
      pause_d   = 1'b0;
      changed_d = 1'b1;
    end else if (rise[1]) begin
      pause_d = ~pause_q;
    end
  end

  assign song_num     = song_q;
  assign pause        = pause_q;
  assign song_changed = changed_q;

endmodule

// File: tb/tb_song_select_controller.sv
// tb/tb_song_select_controller.sv - directed vector bench for song_select_controller

module tb_song_select_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] button;
  logic [2:0] mode;
  logic [2:0] song_num;
  logic       pause;
  logic       song_changed;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_total = 0;
  int base;
  int exp_song;

  typedef struct {
    logic [2:0] mode;
    logic [2:0] btn;
    int         len;
    int         exp_song;
    logic       exp_pause;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [18];
  int   steps [6];

  song_select_controller #(
    .NUM_SONGS   (5),
    .SONG_W      (3),
    .DEBOUNCE_CYC(4),
    .HOLD_CYC    (20),
    .REPEAT_CYC  (8),
    .AUTO_MODE   (3'b011),
    .LEARN_MODE  (3'b111)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .button      (button),
    .mode        (mode),
    .song_num    (song_num),
    .pause       (pause),
    .song_changed(song_changed)
  );

  always #5 clk = ~clk;

  // Count song_changed cycles mid-cycle.
  always @(negedge clk) begin
    if (song_changed === 1'b1) pulse_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    mode   = v.mode;
    button = v.btn;
    base   = pulse_total;
    repeat (v.len) tick();
    button = 3'b000;
    repeat (16) tick();
    check($sformatf("v%0d_song", idx), int'(song_num), v.exp_song);
    check($sformatf("v%0d_pause", idx), int'(pause), int'(v.exp_pause));
    check($sformatf("v%0d_pulses", idx), pulse_total - base, v.exp_pulses);
  endtask

  initial begin
    // mode, button, cycles held, song, pause, song_changed pulses
    vecs[0]  = '{3'b011, 3'b100, 3,  0, 1'b0, 0};
    vecs[1]  = '{3'b011, 3'b100, 10, 1, 1'b0, 1};
    vecs[2]  = '{3'b011, 3'b100, 10, 2, 1'b0, 1};
    vecs[3]  = '{3'b011, 3'b100, 10, 3, 1'b0, 1};
    vecs[4]  = '{3'b011, 3'b100, 10, 4, 1'b0, 1};
    vecs[5]  = '{3'b011, 3'b100, 10, 0, 1'b0, 1};
    vecs[6]  = '{3'b011, 3'b001, 10, 4, 1'b0, 1};
    vecs[7]  = '{3'b011, 3'b010, 10, 4, 1'b1, 0};
    vecs[8]  = '{3'b011, 3'b100, 10, 0, 1'b0, 1};
    vecs[9]  = '{3'b011, 3'b010, 10, 0, 1'b1, 0};
    vecs[10] = '{3'b011, 3'b110, 10, 1, 1'b0, 1};
    vecs[11] = '{3'b011, 3'b010, 10, 1, 1'b1, 0};
    vecs[12] = '{3'b111, 3'b000, 1,  1, 1'b0, 0};
    vecs[13] = '{3'b111, 3'b010, 10, 1, 1'b1, 0};
    vecs[14] = '{3'b001, 3'b000, 1,  1, 1'b0, 0};
    vecs[15] = '{3'b001, 3'b100, 10, 1, 1'b0, 0};
    vecs[16] = '{3'b001, 3'b010, 10, 1, 1'b0, 0};
    vecs[17] = '{3'b011, 3'b101, 10, 1, 1'b0, 0};
    steps = '{7, 27, 35, 43, 51, 59};

    rst_n  = 1'b0;
    button = 3'b000;
    mode   = 3'b011;
    repeat (3) tick();
    check("reset_song", int'(song_num), 0);
    check("reset_pause", int'(pause), 0);
    check("reset_changed", int'(song_changed), 0);
    rst_n = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 18; i++) apply(i, vecs[i]);

    // First-sample to song_num latency: DEBOUNCE_CYC+3 edges.
    mode   = 3'b011;
    button = 3'b100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) check("lat_before", int'(song_num), 1);
      if (k == 7) begin
        check("lat_song", int'(song_num), 2);
        check("lat_strobe", int'(song_changed), 1);
      end
      if (k == 8) check("lat_strobe_off", int'(song_changed), 0);
    end
    button = 3'b000;
    repeat (16) tick();

    // Auto-repeat from song 0.
    rst_n = 1'b0;
    tick();
    check("rst2_song", int'(song_num), 0);
    rst_n    = 1'b1;
    button   = 3'b100;
    base     = pulse_total;
    exp_song = 0;
    for (int k = 1; k <= 90; k++) begin
      logic is_step;
      tick();
      is_step = 1'b0;
      for (int j = 0; j < 6; j++) if (steps[j] == k) is_step = 1'b1;
      if (is_step) exp_song = (exp_song + 1) % 5;
      check($sformatf("rpt_song_e%0d", k), int'(song_num), exp_song);
      check($sformatf("rpt_strobe_e%0d", k), int'(song_changed), int'(is_step));
      if (k == 58) button = 3'b000;
    end
    check("rpt_pulses", pulse_total - base, 6);

    // Reset in the middle of a hold with song_num=3.
    apply(100, '{3'b011, 3'b100, 10, 2, 1'b0, 1});
    button = 3'b100;
    for (int k = 1; k <= 17; k++) tick();
    check("midhold_song", int'(song_num), 3);
    rst_n  = 1'b0;
    button = 3'b000;
    #1;
    check("async_rst_song", int'(song_num), 0);
    check("async_rst_pause", int'(pause), 0);
    check("async_rst_changed", int'(song_changed), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    base  = pulse_total;
    repeat (40) tick();
    check("post_rst_song", int'(song_num), 0);
    check("post_rst_pulses", pulse_total - base, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
